// File: rtl/keypad_scan_ctrl.sv
// ---------------------------------------------------------------------------
// keypad_scan_ctrl : row-scan keypad sequencer, frame debounce, event FIFO
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module keypad_scan_ctrl #(
  parameter int ROWS       = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int DEB_FRAMES = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            HCLK,
  input  logic            HRESET,
  input  logic            en,
  input  logic [7:0]      col,
  output logic [ROWS-1:0] row,
  output logic            evt_valid,
  output logic [6:0]      evt_data,
  input  logic            evt_pop,
  output logic            irq,
  output logic            overflow,
  input  logic            ovf_clr
);

  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int NKEY = (2 ** RW) * 8;
  localparam int DW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int AW   = $clog2(FIFO_DEPTH);

  localparam logic [DW-1:0] C_DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [2:0]    C_DEB_LAST   = 3'(DEB_FRAMES - 1);
  localparam logic [RW-1:0] C_ROW_LAST   = RW'(ROWS - 1);
  localparam logic [AW:0]   C_FIFO_FULL  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    EMIT   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   r_q, r_d;
  logic [2:0]      c_q, c_d;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic [7:0]      smp_q, smp_d;

  // ---------------------------------------------------------------- scan FSM
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= IDLE;
      r_q     <= '0;
      c_q     <= '0;
      dwell_q <= '0;
      smp_q   <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      c_q     <= c_d;
      dwell_q <= dwell_d;
      smp_q   <= smp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    c_d     = c_q;
    dwell_d = dwell_q;
    smp_d   = smp_q;
    if (!en) begin
      state_d = IDLE;
      r_d     = '0;
      c_d     = '0;
      dwell_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = SETTLE;
          r_d     = '0;
          dwell_d = '0;
        end
        SETTLE: begin
          if (dwell_q == C_DWELL_LAST) begin
            dwell_d = '0;
            state_d = SAMPLE;
          end else begin
            dwell_d = dwell_q + 1'b1;
          end
        end
        SAMPLE: begin
          smp_d   = col;
          c_d     = '0;
          state_d = EMIT;
        end
        EMIT: begin
          if (c_q == 3'd7) begin
            c_d     = '0;
            r_d     = (r_q == C_ROW_LAST) ? '0 : r_q + 1'b1;
            state_d = SETTLE;
          end else begin
            c_d = c_q + 3'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    row = '0;
    if (state_q != IDLE) row = ROWS'(1) << r_q;
  end

  // ---------------------------------------------------------------- debounce
  logic [NKEY-1:0] stable_q;
  logic [2:0]      cnt_q [NKEY];
  logic [RW+2:0]   key_idx;
  logic            smp_bit;
  logic            deb_stable_d;
  logic [2:0]      deb_cnt_d;
  logic            deb_upd;
  logic            push;
  logic [6:0]      push_data;

  assign deb_upd = en && (state_q == EMIT);

  always_comb begin
    key_idx      = {r_q, c_q};
    smp_bit      = smp_q[c_q];
    deb_stable_d = stable_q[key_idx];
    deb_cnt_d    = 3'd0;
    push         = 1'b0;
    if (smp_bit != stable_q[key_idx]) begin
      if (cnt_q[key_idx] == C_DEB_LAST) begin
        deb_stable_d = smp_bit;
        push         = deb_upd;
      end else begin
        deb_cnt_d = cnt_q[key_idx] + 3'd1;
      end
    end
    push_data = {smp_bit, 3'(r_q), c_q};
  end

  // Dropping en forgets every key so a re-enable starts from "all released".
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      stable_q <= '0;
      for (int k = 0; k < NKEY; k++) cnt_q[k] <= '0;
    end else if (!en) begin
      stable_q <= '0;
      for (int k = 0; k < NKEY; k++) cnt_q[k] <= '0;
    end else if (deb_upd) begin
      stable_q[key_idx] <= deb_stable_d;
      cnt_q[key_idx]    <= deb_cnt_d;
    end
  end

  // ---------------------------------------------------------------- event FIFO
  logic [6:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   fcnt_q, fcnt_d;
  logic          ovf_q, ovf_d;
  logic          full, pop_ok, wr_ok, drop;

  assign full   = (fcnt_q == C_FIFO_FULL);
  assign pop_ok = evt_pop && (fcnt_q != '0);
  assign wr_ok  = push && (!full || pop_ok);
  assign drop   = push && full && !pop_ok;

  always_comb begin
    fcnt_d = fcnt_q;
    if (wr_ok && !pop_ok)      fcnt_d = fcnt_q + 1'b1;
    else if (!wr_ok && pop_ok) fcnt_d = fcnt_q - 1'b1;
    ovf_d = ovf_q;
    if (drop)         ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      wr_q   <= '0;
      rd_q   <= '0;
      fcnt_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (wr_ok)  wr_q <= wr_q + 1'b1;
      if (pop_ok) rd_q <= rd_q + 1'b1;
      fcnt_q <= fcnt_d;
      ovf_q  <= ovf_d;
    end
  end

  always_ff @(posedge HCLK) begin
    if (wr_ok) mem[wr_q] <= push_data;
  end

  assign evt_valid = (fcnt_q != '0);
  assign evt_data  = evt_valid ? mem[rd_q] : 7'd0;
  assign irq       = evt_valid;
  assign overflow  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_keypad_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_keypad_scan_ctrl : scoreboard bench with a modelled key matrix
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_keypad_scan_ctrl;

  localparam int ROWS       = 4;
  localparam int SCAN_DIV   = 4;
  localparam int DEB_FRAMES = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int ROW_CYC    = SCAN_DIV + 9;
  localparam int FRAME      = ROWS * ROW_CYC;

  logic            HCLK = 1'b0;
  logic            HRESET = 1'b1;
  logic            en = 1'b0;
  logic [7:0]      col;
  logic [ROWS-1:0] row;
  logic            evt_valid;
  logic [6:0]      evt_data;
  logic            evt_pop = 1'b0;
  logic            irq;
  logic            overflow;
  logic            ovf_clr = 1'b0;

  logic [7:0] keys [ROWS];
  logic [6:0] exp_q [$];
  logic [6:0] obs_q [$];
  logic [6:0] e, o;
  int n_cmp = 0;
  int n_mis = 0;
  int irq_bad = 0;

  keypad_scan_ctrl #(
    .ROWS(ROWS), .SCAN_DIV(SCAN_DIV), .DEB_FRAMES(DEB_FRAMES), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .en(en), .col(col), .row(row),
    .evt_valid(evt_valid), .evt_data(evt_data), .evt_pop(evt_pop),
    .irq(irq), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  always #5 HCLK = ~HCLK;

  // Passive matrix: the driven row connects its closed keys to the columns.
  always_comb begin
    col = '0;
    for (int r = 0; r < ROWS; r++) if (row[r]) col = col | keys[r];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic run(input int cycles, input bit do_pop);
    for (int i = 0; i < cycles; i++) begin
      @(negedge HCLK);
      if (irq !== evt_valid) irq_bad++;
      if (do_pop && evt_valid) begin
        obs_q.push_back(evt_data);
        evt_pop = 1'b1;
      end else begin
        evt_pop = 1'b0;
      end
    end
    if (evt_pop) begin
      @(negedge HCLK);
      evt_pop = 1'b0;
    end
  endtask

  // Returns at the first cycle in which row idx becomes driven.
  task automatic wait_row(input int idx, output bit ok);
    int n;
    n = 0;
    while (row == ROWS'(1 << idx) && n < 3 * FRAME) begin @(negedge HCLK); n++; end
    while (row != ROWS'(1 << idx) && n < 3 * FRAME) begin @(negedge HCLK); n++; end
    ok = (row == ROWS'(1 << idx));
  endtask

  task automatic test_reset;
    repeat (3) @(negedge HCLK);
    n_cmp++;
    if ({row, evt_valid, evt_data, irq, overflow} !== '0) begin
      n_mis++;
      $display("FAIL reset_outputs: got row=%b v=%b d=%b irq=%b ovf=%b, expected all 0",
               row, evt_valid, evt_data, irq, overflow);
    end
    HRESET = 1'b0;
    @(negedge HCLK);
  endtask

  task automatic test_row_sequence;
    logic [ROWS-1:0] exp_row;
    int bad;
    bad = 0;
    en = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge HCLK);
      exp_row = ROWS'(1 << ((i / ROW_CYC) % ROWS));
      n_cmp++;
      if (row !== exp_row) begin
        n_mis++;
        if (bad < 4) $display("FAIL row_seq[%0d]: got %b, expected %b", i, row, exp_row);
        bad++;
      end
    end
    n_cmp++;
    if (evt_valid !== 1'b0) begin
      n_mis++;
      $display("FAIL idle_no_event: evt_valid=%b, expected 0", evt_valid);
    end
  endtask

  task automatic test_press_release;
    keys[1] = 8'h20;
    exp_q.push_back(7'b1_001_101);
    run(FRAME - 2, 1'b1);
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_mis++;
      $display("FAIL press_too_early: got %0d events after <1 frame, expected 0", obs_q.size());
    end
    run(2 * FRAME + 10, 1'b1);
    keys[1] = 8'h00;
    exp_q.push_back(7'b0_001_101);
    run(3 * FRAME, 1'b1);
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_mis++;
      $display("FAIL press_release_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_mis++;
        $display("FAIL press_release_data: got %b, expected %b", o, e);
      end
    end
    exp_q.delete();
    obs_q.delete();
    n_cmp++;
    if (irq_bad != 0) begin
      n_mis++;
      $display("FAIL irq_follows_valid: %0d cycles with irq!=evt_valid, expected 0", irq_bad);
    end
  endtask

  task automatic test_glitch;
    bit ok;
    for (int p = 0; p < 2; p++) begin
      wait_row(1, ok);
      n_cmp++;
      if (!ok) begin
        n_mis++;
        $display("FAIL glitch_row_wait: row=%b, expected 0010", row);
      end
      keys[1] = 8'h20;
      run(ROW_CYC, 1'b1);
      keys[1] = 8'h00;
      run(FRAME, 1'b1);
    end
    run(2 * FRAME, 1'b1);
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_mis++;
      $display("FAIL glitch_events: got %0d events, expected 0", obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic test_overflow;
    keys[0] = 8'h1F;
    for (int c = 0; c < 4; c++) exp_q.push_back({1'b1, 3'd0, 3'(c)});
    run(3 * FRAME, 1'b0);
    n_cmp++;
    if (overflow !== 1'b1 || evt_valid !== 1'b1 || irq !== 1'b1 || evt_data !== 7'b1_000_000) begin
      n_mis++;
      $display("FAIL ovf_full: got ovf=%b v=%b irq=%b d=%b, expected 1 1 1 1000000",
               overflow, evt_valid, irq, evt_data);
    end
    run(10, 1'b1);
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_mis++;
      $display("FAIL ovf_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_mis++;
        $display("FAIL ovf_data: got %b, expected %b", o, e);
      end
    end
    exp_q.delete();
    obs_q.delete();
    n_cmp++;
    if (overflow !== 1'b1) begin
      n_mis++;
      $display("FAIL ovf_sticky: got %b, expected 1", overflow);
    end
    ovf_clr = 1'b1;
    @(negedge HCLK);
    ovf_clr = 1'b0;
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_mis++;
      $display("FAIL ovf_clear: got %b, expected 0", overflow);
    end
  endtask

  task automatic test_full_push_pop;
    int n;
    keys[0] = 8'h00;
    n = 0;
    while (!evt_valid && n < 3 * FRAME) begin @(negedge HCLK); n++; end
    n_cmp++;
    if (!evt_valid) begin
      n_mis++;
      $display("FAIL fpp_first_event: evt_valid=%b, expected 1", evt_valid);
    end
    repeat (3) @(negedge HCLK);
    evt_pop = 1'b1;
    @(negedge HCLK);
    evt_pop = 1'b0;
    n_cmp++;
    if (overflow !== 1'b0 || evt_data !== 7'b0_000_001) begin
      n_mis++;
      $display("FAIL fpp_head: got ovf=%b d=%b, expected 0 0000001", overflow, evt_data);
    end
    for (int c = 1; c < 5; c++) exp_q.push_back({1'b0, 3'd0, 3'(c)});
    run(10, 1'b1);
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_mis++;
      $display("FAIL fpp_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_mis++;
        $display("FAIL fpp_data: got %b, expected %b", o, e);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_disable_and_reset;
    bit ok;
    keys[2] = 8'h08;
    exp_q.push_back(7'b1_010_011);
    run(3 * FRAME, 1'b1);
    wait_row(2, ok);
    repeat (6) @(negedge HCLK);
    en = 1'b0;
    @(negedge HCLK);
    n_cmp++;
    if (!ok || row !== '0) begin
      n_mis++;
      $display("FAIL en_drop_row: got row=%b (wait ok=%b), expected 0000", row, ok);
    end
    run(60, 1'b1);
    en = 1'b1;
    run(FRAME - 2, 1'b1);
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_mis++;
      $display("FAIL en_drop_events: got %0d events, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_mis++;
        $display("FAIL en_drop_data: got %b, expected %b", o, e);
      end
    end
    exp_q.delete();
    obs_q.delete();
    run(2 * FRAME, 1'b0);
    n_cmp++;
    if (evt_valid !== 1'b1 || evt_data !== 7'b1_010_011) begin
      n_mis++;
      $display("FAIL reenable_press: got v=%b d=%b, expected 1 1010011", evt_valid, evt_data);
    end
    n_cmp++;
    if (irq_bad != 0) begin
      n_mis++;
      $display("FAIL irq_follows_valid_late: %0d bad cycles, expected 0", irq_bad);
    end
    #2 HRESET = 1'b1;
    #1;
    n_cmp++;
    if ({row, evt_valid, evt_data, irq, overflow} !== '0) begin
      n_mis++;
      $display("FAIL async_reset: got row=%b v=%b d=%b irq=%b ovf=%b, expected all 0",
               row, evt_valid, evt_data, irq, overflow);
    end
    @(negedge HCLK);
    HRESET = 1'b0;
    en = 1'b0;
    keys[2] = 8'h00;
  endtask

  initial begin
    for (int r = 0; r < ROWS; r++) keys[r] = 8'h00;
    test_reset();
    test_row_sequence();
    test_press_release();
    test_glitch();
    test_overflow();
    test_full_push_pop();
    test_disable_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
